fifo_rd_packer: RTL and testbench

//   Read-side consumer for the fifo1 async FIFO, clocked in the read domain.

---
 rtl/fifo_rd_packer.sv | 89 ++++++++
 tb/tb_fifo_rd_packer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_packer.sv
// Read-side packer for fifo1. It pops DSIZE-bit entries and packs PACK of
// them into one word, which is offered downstream on a valid/ready port.
module fifo_rd_packer #(
  parameter int DSIZE = 8,
  parameter int PACK  = 4,
  parameter int CNTW  = 16
) (
  input  logic                       rclk,
  input  logic                       rrst,
  input  logic                       rempty,
  input  logic [DSIZE-1:0]           rdata,
  output logic                       rinc,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DSIZE*PACK-1:0]      out_data,
  output logic [$clog2(PACK+1)-1:0]  out_nbytes,
  output logic [CNTW-1:0]            word_cnt
);

  localparam int NW = $clog2(PACK+1);
  localparam int W  = DSIZE*PACK;

  typedef enum logic {FILL, HOLD} state_t;

  state_t          state;
  logic [NW-1:0]   idx;
  logic [NW-1:0]   n;
  logic [W-1:0]    acc;
  logic [W-1:0]    acc_nxt;
  logic            pop;
  logic            last;
  logic            emit;

  // Pop is gated by reset so fifo1 sees no strobe while we are held.
  assign rinc = !rrst && (state == FILL) && !rempty;
  assign pop  = rinc;
  assign n    = idx + NW'(pop);
  assign last = pop && (idx == NW'(PACK-1));
  assign emit = last || (flush && (n != '0));

  always_comb begin
    acc_nxt = acc;
    for (int i = 0; i < PACK; i++) begin
      if (pop && (idx == NW'(i)))
        acc_nxt[i*DSIZE +: DSIZE] = rdata;
    end
  end

  // Lanes are staged in acc so out_data moves only on load and clear.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state      <= FILL;
      idx        <= '0;
      acc        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_nbytes <= '0;
      word_cnt   <= '0;
    end else begin
      unique case (state)
        FILL: begin
          if (emit) begin
            state      <= HOLD;
            out_valid  <= 1'b1;
            out_data   <= acc_nxt;
            out_nbytes <= n;
            acc        <= '0;
            idx        <= '0;
          end else if (pop) begin
            acc <= acc_nxt;
            idx <= n;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state      <= FILL;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_nbytes <= '0;
            word_cnt   <= word_cnt + CNTW'(1);
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: a show-ahead FIFO model feeds it, and a
// scoreboard of popped entries checks every delivered word.
module tb_fifo_rd_packer;

  logic        rclk = 1'b0;
  logic        rrst;
  logic        rempty;
  logic [7:0]  rdata;
  logic        rinc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_nbytes;
  logic [15:0] word_cnt;

  fifo_rd_packer #(.DSIZE(8), .PACK(4), .CNTW(16)) dut (
    .rclk       (rclk),
    .rrst       (rrst),
    .rempty     (rempty),
    .rdata      (rdata),
    .rinc       (rinc),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_nbytes (out_nbytes),
    .word_cnt   (word_cnt)
  );

  always #35 rclk = ~rclk;

  int tests = 0;
  int fails = 0;
  int dlv   = 0;
  logic [7:0]  fq[$];
  logic [7:0]  pend[$];
  logic        prev_valid = 1'b0;
  logic [31:0] prev_data  = '0;

  typedef struct {
    bit          wr;
    logic [7:0]  wd;
    bit          fl;
    bit          rdy;
    bit          e_rinc;
    bit          e_valid;
    logic [2:0]  e_nb;
    logic [31:0] e_data;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[21];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit wr, input logic [7:0] wd,
                       input bit fl, input bit rdy);
    @(negedge rclk);
    if (wr) fq.push_back(wd);
    rempty    = (fq.size() == 0);
    rdata     = rempty ? 8'h00 : fq[0];
    flush     = fl;
    out_ready = rdy;
    #1;
  endtask

  task automatic clk_edge();
    logic        p;
    logic        hs;
    logic [31:0] exp;
    chk("no_underflow", rinc & rempty, 0);
    if (prev_valid && out_valid)
      chk("hold_stable", out_data, prev_data);
    prev_valid = out_valid;
    prev_data  = out_data;
    p  = rinc;
    hs = out_valid && out_ready;
    if (hs) begin
      exp = '0;
      foreach (pend[i]) exp[i*8 +: 8] = pend[i];
      chk("sb_data", out_data, exp);
      chk("sb_nbytes", out_nbytes, pend.size());
    end
    @(posedge rclk);
    if (p && fq.size() > 0) pend.push_back(fq.pop_front());
    if (hs) begin
      dlv += pend.size();
      pend.delete();
    end
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    #1;
    chk("rst_rinc", rinc, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_nbytes", out_nbytes, 0);
    chk("rst_cnt", word_cnt, 0);
    @(posedge rclk);
    pend.delete();
    prev_valid = 1'b0;
    #5;
    rrst = 1'b0;
  endtask

  initial begin
    int npop;
    int written;
    int cyc;
    bit w;

    rrst      = 1'b0;
    rempty    = 1'b1;
    rdata     = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    #2;
    do_reset();

    tbl[0]  = '{1, 8'h11, 0, 1, 1, 0, 0, 32'h0, 16'd0};
    tbl[1]  = '{1, 8'h22, 0, 1, 1, 0, 0, 32'h0, 16'd0};
    tbl[2]  = '{1, 8'h33, 0, 1, 1, 0, 0, 32'h0, 16'd0};
    tbl[3]  = '{1, 8'h44, 0, 1, 1, 0, 0, 32'h0, 16'd0};
    tbl[4]  = '{0, 8'h00, 0, 1, 0, 1, 4, 32'h44332211, 16'd0};
    tbl[5]  = '{0, 8'h00, 0, 1, 0, 0, 0, 32'h0, 16'd1};
    tbl[6]  = '{1, 8'hAA, 0, 0, 1, 0, 0, 32'h0, 16'd1};
    tbl[7]  = '{1, 8'hBB, 0, 0, 1, 0, 0, 32'h0, 16'd1};
    tbl[8]  = '{0, 8'h00, 1, 0, 0, 0, 0, 32'h0, 16'd1};
    tbl[9]  = '{0, 8'h00, 0, 0, 0, 1, 2, 32'h0000BBAA, 16'd1};
    tbl[10] = '{0, 8'h00, 1, 1, 0, 1, 2, 32'h0000BBAA, 16'd1};
    tbl[11] = '{0, 8'h00, 1, 0, 0, 0, 0, 32'h0, 16'd2};
    tbl[12] = '{0, 8'h00, 0, 0, 0, 0, 0, 32'h0, 16'd2};
    tbl[13] = '{1, 8'hCC, 1, 0, 1, 0, 0, 32'h0, 16'd2};
    tbl[14] = '{0, 8'h00, 0, 1, 0, 1, 1, 32'h000000CC, 16'd2};
    tbl[15] = '{1, 8'h55, 0, 1, 1, 0, 0, 32'h0, 16'd3};
    tbl[16] = '{1, 8'h66, 0, 1, 1, 0, 0, 32'h0, 16'd3};
    tbl[17] = '{1, 8'h77, 0, 1, 1, 0, 0, 32'h0, 16'd3};
    tbl[18] = '{1, 8'h88, 0, 1, 1, 0, 0, 32'h0, 16'd3};
    tbl[19] = '{0, 8'h00, 0, 1, 0, 1, 4, 32'h88776655, 16'd3};
    tbl[20] = '{0, 8'h00, 0, 0, 0, 0, 0, 32'h0, 16'd4};

    foreach (tbl[i]) begin
      drive(tbl[i].wr, tbl[i].wd, tbl[i].fl, tbl[i].rdy);
      chk($sformatf("v%0d_rinc", i), rinc, tbl[i].e_rinc);
      chk($sformatf("v%0d_valid", i), out_valid, tbl[i].e_valid);
      chk($sformatf("v%0d_data", i), out_data, tbl[i].e_data);
      chk($sformatf("v%0d_cnt", i), word_cnt, tbl[i].e_cnt);
      if (tbl[i].e_valid)
        chk($sformatf("v%0d_nb", i), out_nbytes, tbl[i].e_nb);
      clk_edge();
    end

    // Backpressure: only one word's worth of pops while out_ready is low.
    npop = 0;
    for (int j = 0; j < 12; j++) begin
      drive(j < 8, 8'(8'h10 + j), 0, 0);
      npop += int'(rinc);
      clk_edge();
    end
    chk("bp_pops", npop, 4);
    chk("bp_fifo_left", fq.size(), 4);
    drive(0, 8'h00, 0, 0);
    chk("bp_valid", out_valid, 1);
    chk("bp_data", out_data, 32'h13121110);
    clk_edge();
    drive(0, 8'h00, 0, 1);
    clk_edge();
    drive(0, 8'h00, 0, 1);
    chk("bp_resume", rinc, 1);
    clk_edge();
    for (int j = 0; j < 3; j++) begin
      drive(0, 8'h00, 0, 1);
      clk_edge();
    end
    drive(0, 8'h00, 0, 1);
    chk("bp_word2", out_data, 32'h17161514);
    chk("bp_word2_valid", out_valid, 1);
    clk_edge();

    // Reset while a word is held and the counter is nonzero.
    for (int j = 0; j < 4; j++) begin
      drive(1, 8'(j + 1), 0, 0);
      clk_edge();
    end
    drive(0, 8'h00, 0, 0);
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_cnt", word_cnt, 6);
    do_reset();

    // Random writes with gaps against the pop-order scoreboard.
    written = 0;
    dlv     = 0;
    cyc     = 0;
    while (cyc < 3000 && !(written == 60 && dlv == 60)) begin
      w = (written < 60) && (fq.size() < 16) && ($urandom_range(0, 2) != 0);
      drive(w, 8'($urandom), 0, $urandom_range(0, 3) != 0);
      if (w) written++;
      clk_edge();
      cyc++;
    end
    chk("rand_written", written, 60);
    chk("rand_delivered", dlv, 60);
    drive(0, 8'h00, 0, 0);
    chk("rand_word_cnt", word_cnt, 15);
    clk_edge();

    // Reset after three pops discards the partial word.
    for (int j = 0; j < 3; j++) begin
      drive(1, 8'(8'hA1 + j), 0, 0);
      clk_edge();
    end
    drive(1, 8'hA4, 0, 0);
    do_reset();
    for (int j = 0; j < 4; j++) begin
      drive(j < 3, 8'(8'hA5 + j), 0, 1);
      clk_edge();
    end
    drive(0, 8'h00, 0, 1);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_lane0", out_data[7:0], 8'hA4);
    chk("post_rst_word", out_data, 32'hA7A6A5A4);
    clk_edge();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
